// File: rtl/srv_bus_pkg.sv
// Shared types and helpers for the single-master to N-slave bus demultiplexer.
//   bus_req_t : request payload broadcast to every slave (addr, we, wdata, wstrb)
//   bus_rsp_t : response payload returned to the master (rdata, err)
//   ctr_width : bit width needed to hold the values 0..max_val
//   err_idx   : target index of the internal error responder (one past the last slave)
package srv_bus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } bus_rsp_t;

  // Data returned by the internal error responder.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int err_idx(input int max_region);
    return max_region;
  endfunction

endpackage

// File: rtl/srv_addr_hit_v1.sv
// Address region matcher: raises one hit bit per region whose inclusive
// [start,end] range contains the address. Overlaps may raise several bits;
// the consumer resolves priority.
//   addr   : request address
//   ds_hit : one bit per region, bit i set when REGION[i][0] <= addr <= REGION[i][1]
module srv_addr_hit_v1
  import srv_bus_pkg::*;
#(
  parameter int          MAX_REGION = 2,
  parameter logic [31:0] REGION [0:MAX_REGION-1][0:1] =
    '{'{32'h5000_0000, 32'h5FFF_FFFF}, '{32'h6000_0000, 32'h6FFF_FFFF}}
) (
  input  logic [31:0]           addr,
  output logic [MAX_REGION-1:0] ds_hit
);

  // Range compare against every region.
  always_comb begin
    ds_hit = {MAX_REGION{1'b0}};
    for (int i = 0; i < MAX_REGION; i++) begin
      ds_hit[i] = (addr >= REGION[i][0]) && (addr <= REGION[i][1]);
    end
  end

endmodule

// File: rtl/srv_bus_demux_v1.sv
// Single-master to N-slave request/response demultiplexer.
// Steers each request to the lowest-index matching slave (or to an internal
// error responder on a miss) and returns responses in issue order by only
// allowing outstanding requests to a single target at a time.
//   clk, rst             : clock, asynchronous active-high reset
//   us_req_*             : master request channel (valid/ready, addr, we, wdata, wstrb)
//   us_rsp_*             : master response channel (valid/ready, rdata, err)
//   ds_req_valid/ready   : per-slave request handshake
//   ds_req_addr/we/...   : request payload broadcast to all slaves
//   ds_rsp_valid/ready   : per-slave response handshake
//   ds_rsp_rdata/err     : per-slave response payload, slave i at [32*i +: 32]
module srv_bus_demux_v1
  import srv_bus_pkg::*;
#(
  parameter int          MAX_REGION      = 2,
  parameter logic [31:0] REGION [0:MAX_REGION-1][0:1] =
    '{'{32'h5000_0000, 32'h5FFF_FFFF}, '{32'h6000_0000, 32'h6FFF_FFFF}},
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     us_req_valid,
  output logic                     us_req_ready,
  input  logic [31:0]              us_req_addr,
  input  logic                     us_req_we,
  input  logic [31:0]              us_req_wdata,
  input  logic [3:0]               us_req_wstrb,
  output logic                     us_rsp_valid,
  input  logic                     us_rsp_ready,
  output logic [31:0]              us_rsp_rdata,
  output logic                     us_rsp_err,
  output logic [MAX_REGION-1:0]    ds_req_valid,
  input  logic [MAX_REGION-1:0]    ds_req_ready,
  output logic [31:0]              ds_req_addr,
  output logic                     ds_req_we,
  output logic [31:0]              ds_req_wdata,
  output logic [3:0]               ds_req_wstrb,
  input  logic [MAX_REGION-1:0]    ds_rsp_valid,
  output logic [MAX_REGION-1:0]    ds_rsp_ready,
  input  logic [MAX_REGION*32-1:0] ds_rsp_rdata,
  input  logic [MAX_REGION-1:0]    ds_rsp_err
);

  localparam int             ERR_IDX   = err_idx(MAX_REGION);
  localparam int             CW        = ctr_width(MAX_OUTSTANDING);
  localparam int             TW        = ctr_width(MAX_REGION);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]  TGT_ERR   = TW'(ERR_IDX);

  logic [MAX_REGION-1:0] ds_hit_s;
  logic [TW-1:0]         sel_s;
  logic                  sel_ready_s;
  logic                  can_issue_s;
  logic                  busy_s;
  logic                  tgt_rsp_valid_s;
  logic                  accept_s;
  logic                  rsp_hs_s;
  bus_req_t              req_s;
  bus_rsp_t              rsp_s;
  logic [CW-1:0]         cnt_r;
  logic [TW-1:0]         tgt_r;

  srv_addr_hit_v1 #(
    .MAX_REGION (MAX_REGION),
    .REGION     (REGION)
  ) u_addr_hit (
    .addr   (us_req_addr),
    .ds_hit (ds_hit_s)
  );

  assign req_s        = '{addr: us_req_addr, we: us_req_we, wdata: us_req_wdata, wstrb: us_req_wstrb};
  assign ds_req_addr  = req_s.addr;
  assign ds_req_we    = req_s.we;
  assign ds_req_wdata = req_s.wdata;
  assign ds_req_wstrb = req_s.wstrb;

  // Priority-encode hits (lowest index wins) and gate the request path.
  always_comb begin
    sel_s       = TGT_ERR;
    // Scan downward so the lowest-index hit is the last one written.
    for (int i = MAX_REGION - 1; i >= 0; i--) begin
      sel_s = ds_hit_s[i] ? TW'(i) : sel_s;
    end
    // The error responder always accepts; real slaves use their own ready.
    sel_ready_s = (sel_s == TGT_ERR);
    for (int i = 0; i < MAX_REGION; i++) begin
      sel_ready_s = (sel_s == TW'(i)) ? ds_req_ready[i] : sel_ready_s;
    end
    // A new target must wait for the old one to drain so responses stay ordered.
    can_issue_s  = (cnt_r == CNT_ZERO) | ((sel_s == tgt_r) & (cnt_r < CNT_MAX));
    us_req_ready = us_req_valid & can_issue_s & sel_ready_s;
    ds_req_valid = {MAX_REGION{1'b0}};
    for (int i = 0; i < MAX_REGION; i++) begin
      ds_req_valid[i] = us_req_valid & can_issue_s & (sel_s == TW'(i));
    end
  end

  // Response mux from the current target; the error responder is the fallback.
  always_comb begin
    busy_s          = (cnt_r != CNT_ZERO);
    tgt_rsp_valid_s = 1'b1;
    rsp_s.rdata     = ERR_RDATA;
    rsp_s.err       = 1'b1;
    for (int i = 0; i < MAX_REGION; i++) begin
      tgt_rsp_valid_s = (tgt_r == TW'(i)) ? ds_rsp_valid[i]          : tgt_rsp_valid_s;
      rsp_s.rdata     = (tgt_r == TW'(i)) ? ds_rsp_rdata[32*i +: 32] : rsp_s.rdata;
      rsp_s.err       = (tgt_r == TW'(i)) ? ds_rsp_err[i]            : rsp_s.err;
    end
    us_rsp_valid = busy_s & tgt_rsp_valid_s;
    us_rsp_rdata = rsp_s.rdata;
    us_rsp_err   = rsp_s.err;
    // Non-target slaves and anything arriving while idle are never acknowledged.
    ds_rsp_ready = {MAX_REGION{1'b0}};
    for (int i = 0; i < MAX_REGION; i++) begin
      ds_rsp_ready[i] = us_rsp_ready & busy_s & (tgt_r == TW'(i));
    end
  end

  assign accept_s = us_req_valid & us_req_ready;
  assign rsp_hs_s = us_rsp_valid & us_rsp_ready;

  // Current target and outstanding-transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
      tgt_r <= {TW{1'b0}};
    end else begin
      if (accept_s) begin
        tgt_r <= sel_s;
      end
      case ({accept_s, rsp_hs_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_srv_bus_demux_v1.sv
// Self-checking bench for srv_bus_demux_v1: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_srv_bus_demux_v1;

  localparam int NR   = 2;
  localparam int MAXO = 4;
  localparam int ERRT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        us_req_valid, us_req_ready, us_req_we;
  logic [31:0] us_req_addr, us_req_wdata;
  logic [3:0]  us_req_wstrb;
  logic        us_rsp_valid, us_rsp_ready, us_rsp_err;
  logic [31:0] us_rsp_rdata;
  logic [1:0]  ds_req_valid, ds_req_ready, ds_rsp_valid, ds_rsp_ready, ds_rsp_err;
  logic [31:0] ds_req_addr, ds_req_wdata;
  logic        ds_req_we;
  logic [3:0]  ds_req_wstrb;
  logic [63:0] ds_rsp_rdata;

  // Second instance with overlapping regions, only its decode is observed.
  logic        ov_valid, ov_req_ready, ov_rsp_valid, ov_rsp_err, ov_we;
  logic [31:0] ov_addr, ov_rsp_rdata, ov_ds_addr, ov_ds_wdata;
  logic [1:0]  ov_ds_req_valid, ov_ds_rsp_ready;
  logic [3:0]  ov_ds_wstrb;

  int total = 0;
  int bad   = 0;
  int q_tgt[$];

  logic [31:0] reg_lo [NR] = '{32'h5000_0000, 32'h6000_0000};
  logic [31:0] reg_hi [NR] = '{32'h5FFF_FFFF, 32'h6FFF_FFFF};
  logic [31:0] addr_pool [8] = '{32'h5000_0000, 32'h5FFF_FFFC, 32'h5123_4560, 32'h6000_0000,
                                 32'h6FFF_FFFC, 32'h6ABC_0000, 32'h7000_0000, 32'h4FFF_FFFC};

  always #5 clk = ~clk;

  srv_bus_demux_v1 #(.MAX_REGION(NR), .MAX_OUTSTANDING(MAXO)) u_dut (
    .clk(clk), .rst(rst),
    .us_req_valid(us_req_valid), .us_req_ready(us_req_ready), .us_req_addr(us_req_addr),
    .us_req_we(us_req_we), .us_req_wdata(us_req_wdata), .us_req_wstrb(us_req_wstrb),
    .us_rsp_valid(us_rsp_valid), .us_rsp_ready(us_rsp_ready), .us_rsp_rdata(us_rsp_rdata),
    .us_rsp_err(us_rsp_err),
    .ds_req_valid(ds_req_valid), .ds_req_ready(ds_req_ready), .ds_req_addr(ds_req_addr),
    .ds_req_we(ds_req_we), .ds_req_wdata(ds_req_wdata), .ds_req_wstrb(ds_req_wstrb),
    .ds_rsp_valid(ds_rsp_valid), .ds_rsp_ready(ds_rsp_ready), .ds_rsp_rdata(ds_rsp_rdata),
    .ds_rsp_err(ds_rsp_err)
  );

  srv_bus_demux_v1 #(
    .MAX_REGION(NR),
    .REGION('{'{32'h5000_0000, 32'h5FFF_FFFF}, '{32'h4000_0000, 32'h5FFF_FFFF}}),
    .MAX_OUTSTANDING(MAXO)
  ) u_dut_ovl (
    .clk(clk), .rst(rst),
    .us_req_valid(ov_valid), .us_req_ready(ov_req_ready), .us_req_addr(ov_addr),
    .us_req_we(1'b0), .us_req_wdata(32'h0000_0000), .us_req_wstrb(4'h0),
    .us_rsp_valid(ov_rsp_valid), .us_rsp_ready(1'b0), .us_rsp_rdata(ov_rsp_rdata),
    .us_rsp_err(ov_rsp_err),
    .ds_req_valid(ov_ds_req_valid), .ds_req_ready(2'b11), .ds_req_addr(ov_ds_addr),
    .ds_req_we(ov_we), .ds_req_wdata(ov_ds_wdata), .ds_req_wstrb(ov_ds_wstrb),
    .ds_rsp_valid(2'b00), .ds_rsp_ready(ov_ds_rsp_ready), .ds_rsp_rdata(64'h0),
    .ds_rsp_err(2'b00)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < NR; i++) begin
      if (a >= reg_lo[i] && a <= reg_hi[i]) return i;
    end
    return ERRT;
  endfunction

  // One cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic we,
                      input logic [1:0] qrdy, input logic [1:0] rv,
                      input logic [63:0] rd, input logic [1:0] er, input logic mr);
    int sel, cur, n;
    logic can, e_rdy, e_rv;
    logic [1:0] e_dsv, e_dsr;
    logic [31:0] e_rdata;
    logic e_err;
    @(negedge clk);
    us_req_valid = v;    us_req_addr = a;    us_req_we = we;
    us_req_wdata = $urandom; us_req_wstrb = 4'($urandom);
    ds_req_ready = qrdy; ds_rsp_valid = rv;  ds_rsp_rdata = rd;
    ds_rsp_err   = er;   us_rsp_ready = mr;
    #1;
    n     = q_tgt.size();
    sel   = ref_sel(a);
    cur   = (n > 0) ? q_tgt[0] : ERRT;
    can   = (n == 0) || (sel == cur && n < MAXO);
    e_rdy = v && can && ((sel == ERRT) ? 1'b1 : qrdy[sel]);
    e_dsv = (v && can && sel < ERRT) ? (2'b01 << sel) : 2'b00;
    e_rv  = (n > 0) && ((cur == ERRT) ? 1'b1 : rv[cur]);
    e_dsr = (mr && n > 0 && cur < ERRT) ? (2'b01 << cur) : 2'b00;
    chk("us_req_ready", {63'd0, us_req_ready}, {63'd0, e_rdy});
    chk("ds_req_valid", {62'd0, ds_req_valid}, {62'd0, e_dsv});
    chk("us_rsp_valid", {63'd0, us_rsp_valid}, {63'd0, e_rv});
    chk("ds_rsp_ready", {62'd0, ds_rsp_ready}, {62'd0, e_dsr});
    chk("ds_req_addr",  {32'd0, ds_req_addr},  {32'd0, a});
    chk("ds_req_wdata", {32'd0, ds_req_wdata}, {32'd0, us_req_wdata});
    if (e_rv) begin
      e_rdata = (cur == ERRT) ? 32'h0000_0000 : rd[32*cur +: 32];
      e_err   = (cur == ERRT) ? 1'b1 : er[cur];
      chk("us_rsp_rdata", {32'd0, us_rsp_rdata}, {32'd0, e_rdata});
      chk("us_rsp_err",   {63'd0, us_rsp_err},   {63'd0, e_err});
    end
    if (e_rv && mr) void'(q_tgt.pop_front());
    if (e_rdy) q_tgt.push_back(sel);
  endtask

  task automatic drain();
    for (int k = 0; k < 12; k++) begin
      if (q_tgt.size() > 0) step(1'b0, 32'h0, 1'b0, 2'b00, 2'b11, {32'h1111_2222, 32'h3333_4444}, 2'b00, 1'b1);
    end
    chk("drained", {32'd0, 32'(q_tgt.size())}, 64'd0);
  endtask

  initial begin
    us_req_valid = 1'b0; us_req_addr = 32'h0; us_req_we = 1'b0; us_req_wdata = 32'h0;
    us_req_wstrb = 4'h0; us_rsp_ready = 1'b0; ds_req_ready = 2'b00; ds_rsp_valid = 2'b00;
    ds_rsp_rdata = 64'h0; ds_rsp_err = 2'b00; ov_valid = 1'b0; ov_addr = 32'h0;

    // Reset state with responses offered: nothing must be acknowledged.
    @(negedge clk);
    us_rsp_ready = 1'b1; ds_rsp_valid = 2'b11; ds_req_ready = 2'b11;
    #1;
    chk("rst_req_ready",  {63'd0, us_req_ready}, 64'd0);
    chk("rst_rsp_valid",  {63'd0, us_rsp_valid}, 64'd0);
    chk("rst_ds_req_vld", {62'd0, ds_req_valid}, 64'd0);
    chk("rst_ds_rsp_rdy", {62'd0, ds_rsp_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Spurious responses while idle are ignored.
    step(1'b0, 32'h0, 1'b0, 2'b11, 2'b11, {32'h0, 32'h0}, 2'b11, 1'b1);

    // Simple read through slave0.
    step(1'b1, 32'h5000_0010, 1'b0, 2'b01, 2'b00, 64'h0, 2'b00, 1'b1);
    step(1'b0, 32'h0, 1'b0, 2'b00, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00, 1'b1);
    chk("dead_beef_drained", {32'd0, 32'(q_tgt.size())}, 64'd0);

    // Fill slave1 to the outstanding limit, then observe the stall and recovery.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'h6000_0000 + 32'(4*k), 1'b0, 2'b10, 2'b00, 64'h0, 2'b00, 1'b1);
    step(1'b1, 32'h6000_0010, 1'b0, 2'b10, 2'b00, 64'h0, 2'b00, 1'b1);
    step(1'b1, 32'h6000_0010, 1'b0, 2'b10, 2'b10, {32'hCAFE_0001, 32'h0}, 2'b00, 1'b1);
    step(1'b1, 32'h6000_0010, 1'b0, 2'b10, 2'b10, {32'hCAFE_0002, 32'h0}, 2'b10, 1'b1);
    drain();

    // Cross-target request stalls until the previous target drains.
    step(1'b1, 32'h5000_0000, 1'b0, 2'b01, 2'b00, 64'h0, 2'b00, 1'b0);
    step(1'b1, 32'h6000_0000, 1'b0, 2'b11, 2'b10, 64'h0, 2'b00, 1'b1);
    step(1'b1, 32'h6000_0000, 1'b0, 2'b11, 2'b01, {32'h0, 32'h1234_5678}, 2'b00, 1'b1);
    step(1'b1, 32'h6000_0000, 1'b0, 2'b11, 2'b00, 64'h0, 2'b00, 1'b1);
    drain();

    // Miss goes to the error responder.
    step(1'b1, 32'h7000_0000, 1'b1, 2'b00, 2'b00, 64'h0, 2'b00, 1'b0);
    step(1'b0, 32'h0, 1'b0, 2'b11, 2'b11, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 2'b00, 1'b1);

    // Region boundaries.
    step(1'b1, 32'h5FFF_FFFC, 1'b0, 2'b11, 2'b00, 64'h0, 2'b00, 1'b0);
    drain();
    step(1'b1, 32'h6000_0000, 1'b0, 2'b11, 2'b00, 64'h0, 2'b00, 1'b0);
    drain();
    step(1'b1, 32'h6FFF_FFFF, 1'b0, 2'b11, 2'b00, 64'h0, 2'b00, 1'b0);
    drain();

    // Overlapping regions: lowest index wins.
    @(negedge clk);
    ov_valid = 1'b1; ov_addr = 32'h5000_0000;
    #1;
    chk("ovl_both_hit", {62'd0, ov_ds_req_valid}, 64'd1);
    ov_addr = 32'h4000_0000;
    #1;
    chk("ovl_only_r1", {62'd0, ov_ds_req_valid}, 64'd2);
    ov_valid = 1'b0;

    // Reset with two outstanding and the master stalled.
    step(1'b1, 32'h5000_0000, 1'b0, 2'b01, 2'b00, 64'h0, 2'b00, 1'b0);
    step(1'b1, 32'h5000_0004, 1'b0, 2'b01, 2'b00, 64'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b1; us_req_valid = 1'b0; us_rsp_ready = 1'b1; ds_rsp_valid = 2'b11;
    #1;
    chk("mid_rst_rsp_valid",  {63'd0, us_rsp_valid}, 64'd0);
    chk("mid_rst_ds_rsp_rdy", {62'd0, ds_rsp_ready}, 64'd0);
    chk("mid_rst_req_ready",  {63'd0, us_req_ready}, 64'd0);
    chk("mid_rst_ds_req_vld", {62'd0, ds_req_valid}, 64'd0);
    q_tgt.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h6000_0000, 1'b0, 2'b10, 2'b00, 64'h0, 2'b00, 1'b0);
    drain();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom % 4) != 0, addr_pool[$urandom % 8] ^ 32'($urandom % 16) * 32'd4,
           1'($urandom), 2'($urandom), 2'($urandom), {$urandom, $urandom},
           2'($urandom), ($urandom % 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
